// File: rtl/priority_arbiter_rr.sv
// Registered N-way arbiter: fixed priority or round-robin selection, with a
// bounded hold that forces the owner off the grant when others are waiting.
module priority_arbiter_rr #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [N-1:0]  requests,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_id
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t        r_state;
  logic [7:0]    r_hold;
  logic [IW-1:0] r_ptr;
  logic [N-1:0]  r_grant;
  logic          r_grant_valid;
  logic [IW-1:0] r_grant_id;

  state_t        w_state_next;
  logic [7:0]    w_hold_next;
  logic [IW-1:0] w_ptr_next;
  logic [N-1:0]  w_grant_next;
  logic          w_grant_valid_next;
  logic [IW-1:0] w_grant_id_next;

  logic          w_owner_req;
  logic          w_others;
  logic          w_force;
  logic [N-1:0]  w_arb_req;
  logic [N-1:0]  w_rot_req;
  logic          w_win_valid;
  logic [IW-1:0] w_fx_idx;
  logic [IW-1:0] w_rr_off;
  logic [IW:0]   w_rr_sum;
  logic [IW-1:0] w_rr_idx;
  logic [IW-1:0] w_win_idx;

  function automatic logic [IW-1:0] lowest_idx(input logic [N-1:0] v);
    lowest_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IW'(i);
    end
  endfunction

  // r_grant doubles as the owner one-hot mask while BUSY.
  assign w_owner_req = |(requests & r_grant);
  assign w_others    = |(requests & ~r_grant);
  assign w_force     = (r_state == ST_BUSY) && w_owner_req && w_others && (r_hold == HOLD_MAX);
  assign w_arb_req   = w_force ? (requests & ~r_grant) : requests;
  assign w_win_valid = |w_arb_req;

  // Rotate the candidates so that bit 0 of w_rot_req is the index at ptr.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      logic [IW:0]   w_sum;
      logic [IW-1:0] w_idx;
      assign w_sum = {1'b0, r_ptr} + (IW+1)'(gi);
      assign w_idx = IW'((w_sum >= (IW+1)'(N)) ? (w_sum - (IW+1)'(N)) : w_sum);
      assign w_rot_req[gi] = w_arb_req[w_idx];
    end
  endgenerate

  assign w_fx_idx  = lowest_idx(w_arb_req);
  assign w_rr_off  = lowest_idx(w_rot_req);
  assign w_rr_sum  = {1'b0, r_ptr} + {1'b0, w_rr_off};
  assign w_rr_idx  = IW'((w_rr_sum >= (IW+1)'(N)) ? (w_rr_sum - (IW+1)'(N)) : w_rr_sum);
  assign w_win_idx = mode ? w_rr_idx : w_fx_idx;

  always_comb begin
    w_state_next       = r_state;
    w_hold_next        = r_hold;
    w_ptr_next         = r_ptr;
    w_grant_next       = r_grant;
    w_grant_valid_next = r_grant_valid;
    w_grant_id_next    = r_grant_id;

    if ((r_state == ST_BUSY) && w_owner_req && !w_force) begin
      w_hold_next = (r_hold == HOLD_MAX) ? r_hold : r_hold + 8'd1;
    end else if (w_win_valid) begin
      w_state_next       = ST_BUSY;
      w_hold_next        = 8'd1;
      w_grant_next       = N'(1) << w_win_idx;
      w_grant_valid_next = 1'b1;
      w_grant_id_next    = w_win_idx;
      w_ptr_next         = (w_win_idx == IW'(N - 1)) ? '0 : w_win_idx + IW'(1);
    end else begin
      w_state_next       = ST_IDLE;
      w_hold_next        = 8'd0;
      w_grant_next       = '0;
      w_grant_valid_next = 1'b0;
      w_grant_id_next    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_hold        <= 8'd0;
      r_ptr         <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_hold        <= w_hold_next;
      r_ptr         <= w_ptr_next;
      r_grant       <= w_grant_next;
      r_grant_valid <= w_grant_valid_next;
      r_grant_id    <= w_grant_id_next;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Self-checking bench for priority_arbiter_rr (N=4, MAX_HOLD=4): directed
// scenarios plus a long random run against an owner/hold/pointer model.
module tb_priority_arbiter_rr;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mode = 1'b0;
  logic [N-1:0] requests = '0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;

  int tests_run    = 0;
  int tests_failed = 0;
  bit verbose      = 1'b1;

  // Model: who owns the grant (-1 = nobody), how long, and next RR start.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;

  priority_arbiter_rr #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .requests    (requests),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  task automatic model_pick(input logic [N-1:0] cand);
    int win;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = mode ? (m_ptr + k) % N : k;
      if (win < 0 && cand[i]) win = i;
    end
    m_owner = win;
    m_hold  = 1;
    m_ptr   = (win + 1) % N;
  endtask

  task automatic model_step();
    logic [N-1:0] omask;
    if (rst) begin
      m_owner = -1; m_hold = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      if (requests != 0) model_pick(requests);
    end else begin
      omask = N'(1) << m_owner;
      if (requests[m_owner] && ((requests & ~omask) == 0 || m_hold < MAXH)) begin
        if (m_hold < MAXH) m_hold = m_hold + 1;
      end else if (requests[m_owner]) begin
        model_pick(requests & ~omask);
      end else if (requests != 0) begin
        model_pick(requests);
      end else begin
        m_owner = -1; m_hold = 0;
      end
    end
  endtask

  function automatic logic [N-1:0] model_grant();
    return (m_owner < 0) ? '0 : (N'(1) << m_owner);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (verbose)
      $display("[TB] rst=%0b mode=%0b req=%b -> grant=%b valid=%0b id=%0d",
               rst, mode, requests, grant, grant_valid, grant_id);
  endtask

  task automatic do_reset();
    rst = 1'b1; requests = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; requests = 4'b1111;
    tick(); tick();
    tests_run++;
    if ({grant, grant_valid, grant_id} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: grant=%b valid=%b id=%0d, need 0000/0/0", grant, grant_valid, grant_id);
    end
    rst = 1'b0; requests = '0;
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; requests = 4'b0101;
    tick();
    tests_run++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL fixed_first: grant=%b id=%0d, need 0001 id=0", grant, grant_id);
    end
    requests = 4'b0100;
    tick();
    tests_run++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin
      tests_failed++;
      $display("FAIL fixed_handoff: grant=%b id=%0d, need 0100 id=2", grant, grant_id);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    mode = 1'b1; requests = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if (grant !== exp_seq[k]) begin
        tests_failed++;
        $display("FAIL rr_order[%0d]: grant=%b, need %b", k, grant, exp_seq[k]);
      end
      requests = 4'b1111 & ~exp_seq[k];
    end
  endtask

  task automatic test_forced_release();
    logic [N-1:0] exp_g;
    do_reset();
    mode = 1'b1; requests = 4'b0011;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_g = (k < 4 || k == 8) ? 4'b0001 : 4'b0010;
      tests_run++;
      if (grant !== exp_g) begin
        tests_failed++;
        $display("FAIL forced_release[%0d]: grant=%b, need %b", k, grant, exp_g);
      end
    end
    requests = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests_run++;
      if (grant !== 4'b0001) begin
        tests_failed++;
        $display("FAIL sole_owner_hold[%0d]: grant=%b, need 0001", k, grant);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    mode = 1'b0; requests = 4'b0100;
    tick(); tick(); tick();
    tests_run++;
    if (grant !== 4'b0100) begin
      tests_failed++;
      $display("FAIL mid_hold_setup: grant=%b, need 0100", grant);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_hold_reset: grant=%b valid=%b, need 0000/0", grant, grant_valid);
    end
    rst = 1'b0; mode = 1'b1; requests = 4'b1111;
    tick();
    tests_run++;
    if (grant !== 4'b0001) begin
      tests_failed++;
      $display("FAIL post_reset_ptr: grant=%b, need 0001", grant);
    end
  endtask

  task automatic test_idle_boundary();
    do_reset();
    requests = 4'b0000;
    tick();
    tests_run++;
    if (grant_valid !== 1'b0 || grant_id !== 2'd0 || grant !== 4'b0000) begin
      tests_failed++;
      $display("FAIL idle_outputs: grant=%b valid=%b id=%0d, need 0000/0/0", grant, grant_valid, grant_id);
    end
    mode = 1'b0; requests = 4'b1000;
    tick();
    tests_run++;
    if (grant !== 4'b1000 || grant_id !== 2'd3 || grant_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL top_index: grant=%b id=%0d valid=%b, need 1000 id=3 valid=1", grant, grant_id, grant_valid);
    end
    mode = 1'b1; requests = 4'b1001;
    tick();
    tests_run++;
    if (grant !== 4'b1000) begin
      tests_failed++;
      $display("FAIL mode_toggle_hold: grant=%b, need 1000", grant);
    end
    mode = 1'b0;
    tick();
    tests_run++;
    if (grant !== 4'b1000) begin
      tests_failed++;
      $display("FAIL mode_toggle_back: grant=%b, need 1000", grant);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_g;
    verbose = 1'b0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) requests = N'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) mode = ~mode;
      rst = ($urandom_range(0, 499) == 0);
      tick();
      exp_g = model_grant();
      tests_run++;
      if (grant !== exp_g || grant_id !== 2'((m_owner < 0) ? 0 : m_owner)) begin
        tests_failed++;
        $display("FAIL rand_model[%0d]: grant=%b id=%0d, need %b id=%0d",
                 c, grant, grant_id, exp_g, (m_owner < 0) ? 0 : m_owner);
      end
      tests_run++;
      if ($countones(grant) > 1 || grant_valid !== (grant != 0)) begin
        tests_failed++;
        $display("FAIL rand_onehot_valid[%0d]: grant=%b valid=%b", c, grant, grant_valid);
      end
      tests_run++;
      if (grant_valid ? (grant !== (N'(1) << grant_id)) : (grant_id !== 2'd0)) begin
        tests_failed++;
        $display("FAIL rand_id_consistent[%0d]: grant=%b valid=%b id=%0d", c, grant, grant_valid, grant_id);
      end
    end
    rst = 1'b0;
    verbose = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_forced_release();
    test_reset_mid_hold();
    test_idle_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
